// File: rtl/sram_char_seq_pkg.sv
// Shared encodings for the SRAM characterization sequencer: FSM states,
// run modes, data patterns and measurement-select bit positions.
package sram_char_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0] MODE_WR    = 2'd0;
  localparam logic [1:0] MODE_RD    = 2'd1;
  localparam logic [1:0] MODE_WR_RD = 2'd2;

  localparam logic [1:0] PAT_CONST   = 2'd0;
  localparam logic [1:0] PAT_INC     = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_ADDR    = 2'd3;

  localparam int MEAS_WR_BIT = 0;
  localparam int MEAS_RD_BIT = 1;

endpackage

// File: rtl/sram_char_seq_if.sv
// Single-port SRAM macro bus: the sequencer is master, the macro is slave.
interface sram_char_seq_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
);
  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport master (output sram_we, sram_wmask, sram_addr, sram_din, input sram_dout);
  modport slave  (input sram_we, sram_wmask, sram_addr, sram_din, output sram_dout);
endinterface

// File: rtl/sram_char_patgen.sv
// Combinational data-pattern generator; used for both the write-drive path
// and the delayed expected-data path of the readback compare.
module sram_char_patgen
  import sram_char_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic [1:0]            pattern,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [ADDR_WIDTH:0]   idx,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  always_comb begin
    data = seed;
    case (pattern)
      PAT_CONST:   data = seed;
      PAT_INC:     data = seed + DATA_WIDTH'(idx);
      PAT_CHECKER: data = idx[0] ? ~seed : seed;
      PAT_ADDR:    data = DATA_WIDTH'(addr);
      default:     data = seed;
    endcase
  end
endmodule

// File: rtl/sram_char_seq.sv
// SRAM characterization sequencer: bursts writes/reads over an address range,
// raises a measurement window over the selected phases and counts readback errors.
module sram_char_seq
  import sram_char_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [1:0]             pattern,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [ADDR_WIDTH-1:0]  addr_start,
  input  logic [ADDR_WIDTH:0]    addr_count,
  input  logic [WMASK_WIDTH-1:0] wmask_cfg,
  input  logic [1:0]             meas_sel,
  sram_char_seq_if.master        sram,
  output logic                   busy,
  output logic                   done,
  output logic                   meas_window,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic [ADDR_WIDTH-1:0]  first_err_addr,
  output logic                   err_flag
);
  localparam int IW = ADDR_WIDTH + 1;
  localparam int LW = DATA_WIDTH / WMASK_WIDTH;
  localparam logic [IW-1:0]        IDX_ONE = IW'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);

  state_t                 state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   accept, idx_last, cmp_en;

  logic [1:0]             cfg_mode, cfg_pattern, cfg_meas;
  logic [DATA_WIDTH-1:0]  cfg_seed;
  logic [ADDR_WIDTH-1:0]  cfg_addr_start;
  logic [IW-1:0]          cfg_count;
  logic [WMASK_WIDTH-1:0] cfg_wmask;

  logic                   we_q, we_d, busy_d, done_d, meas_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_n;
  logic [DATA_WIDTH-1:0]  din_q, din_d, drv_data, exp_data, lane_mask;

  logic                   cmp_vld, mismatch;
  logic [IW-1:0]          cmp_idx;
  logic [ADDR_WIDTH-1:0]  cmp_addr;

  // DONE also counts as not busy, so a new run may start on its closing edge
  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign idx_last = (idx + IDX_ONE) == cfg_count;
  assign cmp_en   = (cfg_mode == MODE_WR_RD) || (cfg_mode == 2'd3);
  assign addr_n   = cfg_addr_start + idx_n[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_mode <= '0; cfg_pattern <= '0; cfg_meas <= '0; cfg_seed <= '0;
      cfg_addr_start <= '0; cfg_count <= '0; cfg_wmask <= '0;
    end else if (accept) begin
      cfg_mode <= mode; cfg_pattern <= pattern; cfg_meas <= meas_sel; cfg_seed <= seed;
      cfg_addr_start <= addr_start; cfg_count <= addr_count; cfg_wmask <= wmask_cfg;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE:  if (accept) state_n = S_SETUP;
      S_SETUP: begin
        idx_n = '0;
        if (cfg_count == '0)          state_n = S_DONE;
        else if (cfg_mode == MODE_RD) state_n = S_READ;
        else                          state_n = S_WRITE;
      end
      S_WRITE: begin
        if (idx_last) begin
          idx_n   = '0;
          state_n = (cfg_mode == MODE_WR) ? S_DONE : S_GAP;
        end else idx_n = idx + IDX_ONE;
      end
      S_GAP:   begin idx_n = '0; state_n = S_READ; end
      S_READ:  if (idx_last) state_n = S_DRAIN; else idx_n = idx + IDX_ONE;
      S_DRAIN: state_n = S_DONE;
      S_DONE:  state_n = accept ? S_SETUP : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the SRAM pins are flops
  // that line up with the state register.
  always_comb begin
    we_d    = (state_n == S_WRITE);
    wmask_d = we_d ? cfg_wmask : '0;
    addr_d  = (state_n == S_WRITE || state_n == S_READ) ? addr_n : addr_q;
    din_d   = we_d ? drv_data : din_q;
    busy_d  = !(state_n == S_IDLE || state_n == S_DONE);
    done_d  = (state_n == S_DONE);
    meas_d  = (we_d && cfg_meas[MEAS_WR_BIT]) || (state_n == S_READ && cfg_meas[MEAS_RD_BIT]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0; wmask_q <= '0; addr_q <= '0; din_q <= '0;
      busy <= 1'b0; done <= 1'b0; meas_window <= 1'b0;
    end else begin
      we_q <= we_d; wmask_q <= wmask_d; addr_q <= addr_d; din_q <= din_d;
      busy <= busy_d; done <= done_d; meas_window <= meas_d;
    end
  end

  assign sram.sram_we    = we_q;
  assign sram.sram_wmask = wmask_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_din   = din_q;

  sram_char_patgen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_drv (
    .pattern(cfg_pattern), .seed(cfg_seed), .idx(idx_n), .addr(addr_n), .data(drv_data)
  );

  sram_char_patgen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_exp (
    .pattern(cfg_pattern), .seed(cfg_seed), .idx(cmp_idx), .addr(cmp_addr), .data(exp_data)
  );

  // Read data returns one edge after the macro samples the address
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_vld <= 1'b0; cmp_idx <= '0; cmp_addr <= '0;
    end else begin
      cmp_vld  <= (state == S_READ) && cmp_en;
      cmp_idx  <= idx;
      cmp_addr <= addr_q;
    end
  end

  for (genvar l = 0; l < WMASK_WIDTH; l++) begin : g_lane
    assign lane_mask[l*LW +: LW] = {LW{cfg_wmask[l]}};
  end

  assign mismatch = |((sram.sram_dout ^ exp_data) & lane_mask);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count <= '0; first_err_addr <= '0; err_flag <= 1'b0;
    end else if (cmp_vld && mismatch) begin
      if (err_count != '1) err_count <= err_count + ERR_ONE;
      if (!err_flag) begin
        err_flag       <= 1'b1;
        first_err_addr <= cmp_addr;
      end
    end
  end

endmodule
